// File: rtl/uart_n.sv
// uart_n: parametrised full-duplex UART core.
//   Frame: start(0), DATA_BITS data LSB first, optional parity, STOP_BITS stops(1).
//   TX: bit timing from a CLOCK_RATE/BAUD_RATE divider restarted on each accepted word.
//   RX: 2-flop synchroniser, free-running oversample tick, half-bit start recheck,
//       single mid-bit sample per bit; only the first stop bit is checked.
// Ports:
//   clk, reset               system clock (rising edge), async active-high reset
//   rxEn, rxIn               receiver enable, serial line in (idles high)
//   rxBusy                   receive frame in progress
//   rxDone/rxErr/rxParityErr 1-cycle pulses at the stop-bit sample
//   rxOut[DATA_BITS]         last received word
//   txEn, txStart, txIn      transmitter enable, level send request, word to send
//   txBusy, txDone, txOut    frame on line, 1-cycle end pulse, serial line out
module uart_n #(
  parameter int CLOCK_RATE = 12000000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rxEn,
  input  logic                 rxIn,
  output logic                 rxBusy,
  output logic                 rxDone,
  output logic                 rxErr,
  output logic                 rxParityErr,
  output logic [DATA_BITS-1:0] rxOut,
  input  logic                 txEn,
  input  logic                 txStart,
  input  logic [DATA_BITS-1:0] txIn,
  output logic                 txBusy,
  output logic                 txDone,
  output logic                 txOut
);

  localparam int TX_DIV = CLOCK_RATE / BAUD_RATE;
  localparam int RX_DIV = CLOCK_RATE / (BAUD_RATE * OVERSAMPLE);
  localparam int TXW    = $clog2(TX_DIV);
  localparam int RXW    = $clog2(RX_DIV);
  localparam int SW     = $clog2(OVERSAMPLE);

  localparam logic [TXW-1:0] TX_LAST   = TXW'(TX_DIV - 1);
  localparam logic [RXW-1:0] RX_LAST   = RXW'(RX_DIV - 1);
  localparam logic [SW-1:0]  HALF_LAST = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0]  SAMP_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [3:0]     DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]     STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // ---------------- transmitter ----------------
  state_t                 txState, txStateNext;
  logic [TXW-1:0]         txDiv, txDivNext;
  logic [3:0]             txCnt, txCntNext;
  logic [DATA_BITS-1:0]   txShift, txShiftNext;
  logic                   txPar, txParNext;
  logic                   txOutNext, txBusyNext, txDoneNext;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      txState <= S_IDLE;
      txDiv   <= '0;
      txCnt   <= '0;
      txShift <= '0;
      txPar   <= 1'b0;
      txOut   <= 1'b1;
      txBusy  <= 1'b0;
      txDone  <= 1'b0;
    end else begin
      txState <= txStateNext;
      txDiv   <= txDivNext;
      txCnt   <= txCntNext;
      txShift <= txShiftNext;
      txPar   <= txParNext;
      txOut   <= txOutNext;
      txBusy  <= txBusyNext;
      txDone  <= txDoneNext;
    end
  end

  // txOut is registered: each transition loads the level of the bit being entered.
  always_comb begin
    txStateNext = txState;
    txDivNext   = txDiv;
    txCntNext   = txCnt;
    txShiftNext = txShift;
    txParNext   = txPar;
    txOutNext   = txOut;
    txBusyNext  = txBusy;
    txDoneNext  = 1'b0;
    if (txState == S_IDLE) begin
      txOutNext  = 1'b1;
      txBusyNext = 1'b0;
      if (txEn && txStart) begin
        txStateNext = S_START;
        txShiftNext = txIn;
        txParNext   = (PARITY == 1) ? ~^txIn : ^txIn;
        txDivNext   = '0;
        txOutNext   = 1'b0;
        txBusyNext  = 1'b1;
      end
    end else if (!txEn) begin
      txStateNext = S_IDLE;
      txOutNext   = 1'b1;
      txBusyNext  = 1'b0;
    end else if (txDiv != TX_LAST) begin
      txDivNext = txDiv + 1'b1;
    end else begin
      txDivNext = '0;
      case (txState)
        S_START: begin
          txStateNext = S_DATA;
          txCntNext   = '0;
          txOutNext   = txShift[0];
          txShiftNext = txShift >> 1;
        end
        S_DATA: begin
          if (txCnt == DATA_LAST) begin
            txCntNext = '0;
            if (PARITY != 0) begin
              txStateNext = S_PARITY;
              txOutNext   = txPar;
            end else begin
              txStateNext = S_STOP;
              txOutNext   = 1'b1;
            end
          end else begin
            txCntNext   = txCnt + 1'b1;
            txOutNext   = txShift[0];
            txShiftNext = txShift >> 1;
          end
        end
        S_PARITY: begin
          txStateNext = S_STOP;
          txCntNext   = '0;
          txOutNext   = 1'b1;
        end
        S_STOP: begin
          if (txCnt == STOP_LAST) begin
            txStateNext = S_IDLE;
            txBusyNext  = 1'b0;
            txDoneNext  = 1'b1;
            txOutNext   = 1'b1;
          end else begin
            txCntNext = txCnt + 1'b1;
          end
        end
        default: txStateNext = S_IDLE;
      endcase
    end
  end

  // ---------------- receiver ----------------
  logic                 rxSync1, rxSync2, line, rxTick;
  logic [RXW-1:0]       rxTickCnt;
  state_t               rxState, rxStateNext;
  logic                 rxArmed, rxArmedNext;
  logic [SW-1:0]        rxSamp, rxSampNext;
  logic [3:0]           rxCnt, rxCntNext;
  logic [DATA_BITS-1:0] rxShift, rxShiftNext;
  logic                 rxPar, rxParNext;
  logic [DATA_BITS-1:0] rxOutNext;
  logic                 rxBusyNext, rxDoneNext, rxErrNext, rxParityErrNext;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxSync1   <= 1'b1;
      rxSync2   <= 1'b1;
      rxTickCnt <= '0;
    end else begin
      rxSync1   <= rxIn;
      rxSync2   <= rxSync1;
      rxTickCnt <= (rxTickCnt == RX_LAST) ? '0 : rxTickCnt + 1'b1;
    end
  end

  assign line   = rxSync2;
  assign rxTick = (rxTickCnt == RX_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxState     <= S_IDLE;
      rxArmed     <= 1'b0;
      rxSamp      <= '0;
      rxCnt       <= '0;
      rxShift     <= '0;
      rxPar       <= 1'b0;
      rxOut       <= '0;
      rxBusy      <= 1'b0;
      rxDone      <= 1'b0;
      rxErr       <= 1'b0;
      rxParityErr <= 1'b0;
    end else begin
      rxState     <= rxStateNext;
      rxArmed     <= rxArmedNext;
      rxSamp      <= rxSampNext;
      rxCnt       <= rxCntNext;
      rxShift     <= rxShiftNext;
      rxPar       <= rxParNext;
      rxOut       <= rxOutNext;
      rxBusy      <= rxBusyNext;
      rxDone      <= rxDoneNext;
      rxErr       <= rxErrNext;
      rxParityErr <= rxParityErrNext;
    end
  end

  // rxPar accumulates the XOR of data and parity bits: odd mode expects 1, even 0.
  // Leaving IDLE always disarms, so a held-low line cannot retrigger a frame.
  always_comb begin
    rxStateNext     = rxState;
    rxArmedNext     = rxArmed;
    rxSampNext      = rxSamp;
    rxCntNext       = rxCnt;
    rxShiftNext     = rxShift;
    rxParNext       = rxPar;
    rxOutNext       = rxOut;
    rxBusyNext      = rxBusy;
    rxDoneNext      = 1'b0;
    rxErrNext       = 1'b0;
    rxParityErrNext = 1'b0;
    if (rxState != S_IDLE && !rxEn) begin
      rxStateNext = S_IDLE;
      rxBusyNext  = 1'b0;
      rxArmedNext = 1'b0;
    end else if (rxTick) begin
      case (rxState)
        S_IDLE: begin
          if (line) begin
            rxArmedNext = 1'b1;
          end else if (rxArmed && rxEn) begin
            rxStateNext = S_START;
            rxBusyNext  = 1'b1;
            rxArmedNext = 1'b0;
            rxSampNext  = '0;
          end
        end
        S_START: begin
          if (rxSamp != HALF_LAST) begin
            rxSampNext = rxSamp + 1'b1;
          end else if (line) begin
            rxStateNext = S_IDLE;
            rxBusyNext  = 1'b0;
          end else begin
            rxStateNext = S_DATA;
            rxSampNext  = '0;
            rxCntNext   = '0;
            rxParNext   = 1'b0;
          end
        end
        S_DATA: begin
          if (rxSamp != SAMP_LAST) begin
            rxSampNext = rxSamp + 1'b1;
          end else begin
            rxSampNext  = '0;
            rxShiftNext = {line, rxShift[DATA_BITS-1:1]};
            rxParNext   = rxPar ^ line;
            if (rxCnt == DATA_LAST) begin
              rxCntNext   = '0;
              rxStateNext = (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              rxCntNext = rxCnt + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (rxSamp != SAMP_LAST) begin
            rxSampNext = rxSamp + 1'b1;
          end else begin
            rxSampNext  = '0;
            rxParNext   = rxPar ^ line;
            rxStateNext = S_STOP;
          end
        end
        S_STOP: begin
          if (rxSamp != SAMP_LAST) begin
            rxSampNext = rxSamp + 1'b1;
          end else begin
            rxSampNext      = '0;
            rxOutNext       = rxShift;
            rxDoneNext      = 1'b1;
            rxErrNext       = !line;
            rxParityErrNext = (PARITY == 1) ? !rxPar : (PARITY == 2) ? rxPar : 1'b0;
            rxStateNext     = S_IDLE;
            rxBusyNext      = 1'b0;
            rxArmedNext     = 1'b0;
          end
        end
        default: rxStateNext = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_n.sv
// Directed bench for uart_n.
//   dutA: default parameters, txOut looped to rxIn.
//   dutB: 7 data bits, even parity, 2 stop bits, 160 clk/bit, RX 10 clk/tick;
//         rxIn either looped from txOut or driven directly by the bench.
module tb_uart_n;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       rxEnA, rxBusyA, rxDoneA, rxErrA, rxParityErrA, rxInA;
  logic [7:0] rxOutA, txInA;
  logic       txEnA, txStartA, txBusyA, txDoneA, txOutA;

  logic       rxEnB, rxBusyB, rxDoneB, rxErrB, rxParityErrB, rxInB;
  logic [6:0] rxOutB, txInB;
  logic       txEnB, txStartB, txBusyB, txDoneB, txOutB;
  logic       loopB, rxDrvB;

  assign rxInA = txOutA;
  assign rxInB = loopB ? txOutB : rxDrvB;

  uart_n dutA (
    .clk(clk), .reset(reset),
    .rxEn(rxEnA), .rxIn(rxInA), .rxBusy(rxBusyA), .rxDone(rxDoneA),
    .rxErr(rxErrA), .rxParityErr(rxParityErrA), .rxOut(rxOutA),
    .txEn(txEnA), .txStart(txStartA), .txIn(txInA),
    .txBusy(txBusyA), .txDone(txDoneA), .txOut(txOutA)
  );

  uart_n #(
    .CLOCK_RATE(1536000), .BAUD_RATE(9600), .DATA_BITS(7),
    .PARITY(2), .STOP_BITS(2), .OVERSAMPLE(16)
  ) dutB (
    .clk(clk), .reset(reset),
    .rxEn(rxEnB), .rxIn(rxInB), .rxBusy(rxBusyB), .rxDone(rxDoneB),
    .rxErr(rxErrB), .rxParityErr(rxParityErrB), .rxOut(rxOutB),
    .txEn(txEnB), .txStart(txStartB), .txIn(txInB),
    .txBusy(txBusyB), .txDone(txDoneB), .txOut(txOutB)
  );

  int tests = 0;
  int fails = 0;

  // Event monitors, sampled on the falling edge.
  int doneA = 0, errA = 0, strayA = 0;
  int doneB = 0, errB = 0, perrB = 0, strayB = 0, busyRiseB = 0, busyHighB = 0;
  logic busyPrevB = 1'b0;
  always @(negedge clk) begin
    if (rxDoneA) doneA++;
    if (rxDoneA && rxErrA) errA++;
    if (!rxDoneA && (rxErrA || rxParityErrA)) strayA++;
    if (rxDoneB) doneB++;
    if (rxDoneB && rxErrB) errB++;
    if (rxDoneB && rxParityErrB) perrB++;
    if (!rxDoneB && (rxErrB || rxParityErrB)) strayB++;
    if (rxBusyB && !busyPrevB) busyRiseB++;
    if (rxBusyB) busyHighB++;
    busyPrevB = rxBusyB;
  end

  task automatic sendA(input logic [7:0] d);
    @(negedge clk);
    txInA    = d;
    txStartA = 1'b1;
    @(negedge clk);
    txStartA = 1'b0;
    txInA    = ~d;
  endtask

  task automatic waitTxDoneA(output int busy, output bit timedOut);
    busy = 0;
    timedOut = 1'b1;
    for (int i = 0; i < 20000; i++) begin
      if (txBusyA) busy++;
      if (txDoneA) begin
        timedOut = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic driveB(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rxDrvB = bits[i];
      repeat (159) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rxEnA = 1'b0; txEnA = 1'b0; txStartA = 1'b0; txInA = '0;
    rxEnB = 1'b0; txEnB = 1'b0; txStartB = 1'b0; txInB = '0;
    loopB = 1'b1; rxDrvB = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({txOutA, txBusyA, txDoneA, rxBusyA, rxDoneA, rxErrA, rxParityErrA} !== 7'b1000000) begin
      fails++;
      $display("FAIL reset_flags: got %b, expected 1000000",
               {txOutA, txBusyA, txDoneA, rxBusyA, rxDoneA, rxErrA, rxParityErrA});
    end
    tests++;
    if (rxOutA !== 8'h00) begin
      fails++;
      $display("FAIL reset_rxOut: got %h, expected 00", rxOutA);
    end
    reset = 1'b0;
    repeat (200) @(negedge clk);
  endtask

  task automatic test_loopback();
    int busy, d0, e0;
    bit to;
    d0 = doneA; e0 = errA;
    txEnA = 1'b1; rxEnA = 1'b1;
    sendA(8'h8A);
    waitTxDoneA(busy, to);
    tests++;
    if (to !== 1'b0) begin
      fails++;
      $display("FAIL loop_txDone_timeout: got timeout, expected txDone");
    end
    tests++;
    if (busy < 12499 || busy > 12501) begin
      fails++;
      $display("FAIL loop_txBusy_len: got %0d, expected 12500 +/-1", busy);
    end
    tests++;
    if (rxOutA !== 8'h8A) begin
      fails++;
      $display("FAIL loop_rxOut: got %h, expected 8a", rxOutA);
    end
    tests++;
    if (doneA - d0 !== 1 || errA - e0 !== 0) begin
      fails++;
      $display("FAIL loop_rx_pulses: got done=%0d err=%0d, expected done=1 err=0",
               doneA - d0, errA - e0);
    end
  endtask

  task automatic test_tx_enable();
    int busy, d0, bad;
    bit to;
    @(negedge clk);
    txEnA = 1'b0; txStartA = 1'b1; txInA = 8'h7A;
    d0 = doneA; bad = 0;
    repeat (2400) begin
      @(negedge clk);
      if (txBusyA || !txOutA) bad++;
    end
    tests++;
    if (bad !== 0 || doneA - d0 !== 0) begin
      fails++;
      $display("FAIL txen_low_activity: got busy_cycles=%0d frames=%0d, expected 0 0",
               bad, doneA - d0);
    end
    txEnA = 1'b1;
    @(negedge clk);
    tests++;
    if (txBusyA !== 1'b1) begin
      fails++;
      $display("FAIL txen_rise_busy: got %b, expected 1", txBusyA);
    end
    txStartA = 1'b0;
    txInA = 8'h00;
    waitTxDoneA(busy, to);
    tests++;
    if (to !== 1'b0 || rxOutA !== 8'h7A || doneA - d0 !== 1) begin
      fails++;
      $display("FAIL txen_frame: got timeout=%b rxOut=%h frames=%0d, expected 0 7a 1",
               to, rxOutA, doneA - d0);
    end
  endtask

  task automatic test_parity();
    int busy, d0, p0, e0, k;
    bit to;
    logic [10:0] frame;
    frame = '0;
    d0 = doneB; p0 = perrB; e0 = errB;
    loopB = 1'b1; txEnB = 1'b1; rxEnB = 1'b1;
    @(negedge clk);
    txInB = 7'h55; txStartB = 1'b1;
    @(negedge clk);
    txStartB = 1'b0;
    txInB = 7'h00;
    busy = 0; to = 1'b1; k = 0;
    for (int i = 0; i < 4000; i++) begin
      if (k % 160 == 80 && k / 160 < 11) frame[k / 160] = txOutB;
      if (txBusyB) busy++;
      if (txDoneB) begin
        to = 1'b0;
        break;
      end
      k++;
      @(negedge clk);
    end
    tests++;
    if (to !== 1'b0 || busy !== 1760) begin
      fails++;
      $display("FAIL par_tx_len: got timeout=%b busy=%0d, expected 0 1760", to, busy);
    end
    tests++;
    if (frame !== 11'h6AA) begin
      fails++;
      $display("FAIL par_tx_bits: got %b, expected %b", frame, 11'h6AA);
    end
    tests++;
    if (rxOutB !== 7'h55 || doneB - d0 !== 1 || perrB - p0 !== 0 || errB - e0 !== 0) begin
      fails++;
      $display("FAIL par_rx_good: got rxOut=%h done=%0d perr=%0d err=%0d, expected 55 1 0 0",
               rxOutB, doneB - d0, perrB - p0, errB - e0);
    end
    rxDrvB = 1'b1;
    loopB = 1'b0;
    repeat (100) @(negedge clk);
    d0 = doneB; p0 = perrB; e0 = errB;
    driveB(16'h07AA, 11);
    tests++;
    if (rxOutB !== 7'h55 || doneB - d0 !== 1 || perrB - p0 !== 1 || errB - e0 !== 0) begin
      fails++;
      $display("FAIL par_rx_flip: got rxOut=%h done=%0d perr=%0d err=%0d, expected 55 1 1 0",
               rxOutB, doneB - d0, perrB - p0, errB - e0);
    end
  endtask

  task automatic test_break();
    int d0, e0, p0, r0;
    d0 = doneB; e0 = errB; p0 = perrB; r0 = busyRiseB;
    driveB(16'h005A, 10);
    rxDrvB = 1'b0;
    repeat (800) @(negedge clk);
    tests++;
    if (doneB - d0 !== 1 || errB - e0 !== 1 || perrB - p0 !== 0) begin
      fails++;
      $display("FAIL break_pulses: got done=%0d err=%0d perr=%0d, expected 1 1 0",
               doneB - d0, errB - e0, perrB - p0);
    end
    tests++;
    if (rxOutB !== 7'h2D) begin
      fails++;
      $display("FAIL break_rxOut: got %h, expected 2d", rxOutB);
    end
    tests++;
    if (busyRiseB - r0 !== 1 || rxBusyB !== 1'b0) begin
      fails++;
      $display("FAIL break_no_restart: got rises=%0d busy=%b, expected 1 0",
               busyRiseB - r0, rxBusyB);
    end
    @(negedge clk);
    rxDrvB = 1'b1;
    repeat (320) @(negedge clk);
  endtask

  task automatic test_false_start();
    int d0, r0, h0, s0;
    d0 = doneB; r0 = busyRiseB; h0 = busyHighB; s0 = strayB;
    @(negedge clk);
    rxDrvB = 1'b0;
    repeat (30) @(negedge clk);
    rxDrvB = 1'b1;
    repeat (200) @(negedge clk);
    tests++;
    if (busyRiseB - r0 !== 1 || busyHighB - h0 !== 80) begin
      fails++;
      $display("FAIL false_start_busy: got rises=%0d high=%0d, expected 1 80",
               busyRiseB - r0, busyHighB - h0);
    end
    tests++;
    if (doneB - d0 !== 0 || strayB - s0 !== 0 || rxBusyB !== 1'b0) begin
      fails++;
      $display("FAIL false_start_pulses: got done=%0d stray=%0d busy=%b, expected 0 0 0",
               doneB - d0, strayB - s0, rxBusyB);
    end
  endtask

  task automatic test_reset_midframe();
    int busy, d0, e0;
    bit to;
    txEnA = 1'b1; rxEnA = 1'b1;
    sendA(8'h3C);
    repeat (5600) @(negedge clk);
    tests++;
    if (txBusyA !== 1'b1 || rxBusyA !== 1'b1) begin
      fails++;
      $display("FAIL midframe_pre: got txBusy=%b rxBusy=%b, expected 1 1", txBusyA, rxBusyA);
    end
    #2 reset = 1'b1;
    #1;
    tests++;
    if ({txOutA, txBusyA, txDoneA, rxBusyA, rxDoneA, rxErrA, rxParityErrA} !== 7'b1000000
        || rxOutA !== 8'h00) begin
      fails++;
      $display("FAIL midframe_async_reset: got flags=%b rxOut=%h, expected 1000000 00",
               {txOutA, txBusyA, txDoneA, rxBusyA, rxDoneA, rxErrA, rxParityErrA}, rxOutA);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (300) @(negedge clk);
    d0 = doneA; e0 = errA;
    sendA(8'hC3);
    waitTxDoneA(busy, to);
    tests++;
    if (to !== 1'b0 || rxOutA !== 8'hC3 || doneA - d0 !== 1 || errA - e0 !== 0) begin
      fails++;
      $display("FAIL midframe_after: got timeout=%b rxOut=%h done=%0d err=%0d, expected 0 c3 1 0",
               to, rxOutA, doneA - d0, errA - e0);
    end
    tests++;
    if (strayA !== 0) begin
      fails++;
      $display("FAIL stray_err_pulses_A: got %0d, expected 0", strayA);
    end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_tx_enable();
    test_parity();
    test_break();
    test_false_start();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
